tri_row_buffer: RTL and testbench

- Upstream stage of the lower-triangular complex matrix inverter.
- Accepts a lower-triangular complex matrix as a row-major element stream and stores it in a SIZE x SIZE register array; the upper triangle is held at zero.
- Once loaded, pulses the inverter's start and serves full rows on address request through the inverter's row-fetch handshake.
- Frees itself for the next matrix when the inverter drops busy.

---
 rtl/tri_row_buffer.sv | 162 ++++++++++++++++
 tb/tb_tri_row_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_row_buffer.sv
// Staging buffer for the lower-triangular complex inverter: loads a row-major triangle, starts the
// inverter and serves whole rows. Define TRI_ROW_BUFFER_DIAG_CHECK_EN to build the zero-diagonal flag.
module tri_row_buffer #(
    parameter int SIZE = 16,
    parameter int DW   = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [2*DW-1:0]             elem_i,
    input  logic                        elem_valid_i,
    output logic                        elem_ready_o,
    input  logic [$clog2(SIZE)-1:0]     row_addr_i,
    input  logic                        row_addr_valid_i,
    output logic [SIZE-1:0][2*DW-1:0]   row_o,
    output logic [$clog2(SIZE)-1:0]     row_addr_o,
    output logic                        row_valid_o,
    output logic                        start_o,
    input  logic                        consumer_ready_i,
    input  logic                        consumer_busy_i,
    output logic                        loaded_o,
    input  logic                        flush_i,
    output logic                        diag_zero_o
);

    localparam int AW = $clog2(SIZE);
    localparam int LAST_I = SIZE - 1;
    localparam logic [AW-1:0] LAST = LAST_I[AW-1:0];
    localparam logic [AW:0] SIZE_W = SIZE[AW:0];

    typedef enum logic [1:0] {
        LOAD,
        ARM,
        SERVE
    } state_t;

    state_t state, state_next;

    logic [SIZE-1:0][SIZE-1:0][2*DW-1:0] mem;
    logic [AW-1:0] row_cnt;
    logic [AW-1:0] col_cnt;
    logic          seen_busy;
    logic          accept;
    logic          last_elem;
    logic          release_now;
    logic          addr_in_range;

    assign elem_ready_o  = (state == LOAD);
    assign accept        = elem_valid_i && elem_ready_o && !flush_i;
    assign last_elem     = (row_cnt == LAST) && (col_cnt == LAST);
    assign release_now   = (state == SERVE) && seen_busy && !consumer_busy_i;
    assign addr_in_range = ({1'b0, row_addr_i} < SIZE_W);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD:    if (accept && last_elem) state_next = ARM;
                ARM:     if (consumer_ready_i) state_next = SERVE;
                SERVE:   if (release_now) state_next = LOAD;
                default: state_next = LOAD;
            endcase
        end
    end

    // Upper-triangle entries are never addressed by the load counters, so they keep their reset zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem <= '0;
        end else if (accept) begin
            mem[row_cnt][col_cnt] <= elem_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_cnt     <= '0;
            col_cnt     <= '0;
            row_o       <= '0;
            row_addr_o  <= '0;
            row_valid_o <= 1'b0;
            start_o     <= 1'b0;
            loaded_o    <= 1'b0;
            seen_busy   <= 1'b0;
        end else begin
            start_o     <= 1'b0;
            row_valid_o <= 1'b0;
            if (flush_i) begin
                row_cnt   <= '0;
                col_cnt   <= '0;
                loaded_o  <= 1'b0;
                seen_busy <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (accept) begin
                            if (col_cnt == row_cnt) begin
                                col_cnt <= '0;
                                row_cnt <= last_elem ? '0 : row_cnt + AW'(1);
                            end else begin
                                col_cnt <= col_cnt + AW'(1);
                            end
                            if (last_elem) loaded_o <= 1'b1;
                        end
                    end
                    ARM: begin
                        if (consumer_ready_i) begin
                            start_o   <= 1'b1;
                            seen_busy <= 1'b0;
                        end
                    end
                    SERVE: begin
                        // The inverter is done once busy has been seen high and then drops again.
                        if (release_now) begin
                            row_cnt   <= '0;
                            col_cnt   <= '0;
                            loaded_o  <= 1'b0;
                            seen_busy <= 1'b0;
                        end else begin
                            if (consumer_busy_i) seen_busy <= 1'b1;
                            if (row_addr_valid_i) begin
                                row_valid_o <= 1'b1;
                                row_addr_o  <= row_addr_i;
                                row_o       <= addr_in_range ? mem[row_addr_i] : '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef TRI_ROW_BUFFER_DIAG_CHECK_EN
    // Sign bits are ignored so that both +0.0 and -0.0 on the diagonal raise the flag.
    logic diag_hit;
    assign diag_hit = accept && (row_cnt == col_cnt)
                      && (elem_i[DW-2:0] == '0) && (elem_i[2*DW-2:DW] == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            diag_zero_o <= 1'b0;
        end else if (flush_i || release_now) begin
            diag_zero_o <= 1'b0;
        end else if (diag_hit) begin
            diag_zero_o <= 1'b1;
        end
    end
`else
    assign diag_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_tri_row_buffer.sv
// Self-checking bench for tri_row_buffer (SIZE=4, DW=64): table-driven row reads, hand-written
// handshake/flush/reset sequences and randomized loads checked against a triangular-index model.
module tb_tri_row_buffer;

    localparam int SIZE = 4;
    localparam int DW   = 64;
    localparam int NELEM = SIZE * (SIZE + 1) / 2;

`ifdef TRI_ROW_BUFFER_DIAG_CHECK_EN
    localparam bit DIAG_EN = 1'b1;
`else
    localparam bit DIAG_EN = 1'b0;
`endif

    logic                      clk;
    logic                      rst_n;
    logic [2*DW-1:0]           elem;
    logic                      elem_valid;
    logic                      elem_ready;
    logic [1:0]                row_addr;
    logic                      row_addr_valid;
    logic [SIZE-1:0][2*DW-1:0] row_data;
    logic [1:0]                row_addr_out;
    logic                      row_valid;
    logic                      start;
    logic                      consumer_ready;
    logic                      consumer_busy;
    logic                      loaded;
    logic                      flush;
    logic                      diag_zero;

    int total = 0;
    int bad = 0;

    logic [2*DW-1:0] model_mem [SIZE][SIZE];
    logic [2*DW-1:0] stream [NELEM];

    typedef struct {
        logic [1:0]   addr;
        logic [511:0] row;
    } read_vec_t;

    read_vec_t tbl [5];

    tri_row_buffer #(.SIZE(SIZE), .DW(DW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .elem_i           (elem),
        .elem_valid_i     (elem_valid),
        .elem_ready_o     (elem_ready),
        .row_addr_i       (row_addr),
        .row_addr_valid_i (row_addr_valid),
        .row_o            (row_data),
        .row_addr_o       (row_addr_out),
        .row_valid_o      (row_valid),
        .start_o          (start),
        .consumer_ready_i (consumer_ready),
        .consumer_busy_i  (consumer_busy),
        .loaded_o         (loaded),
        .flush_i          (flush),
        .diag_zero_o      (diag_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*DW-1:0] ek(input int k);
        return {64'(k + 100), 64'(k)};
    endfunction

    function automatic logic [511:0] model_row(input int r);
        return {model_mem[r][3], model_mem[r][2], model_mem[r][1], model_mem[r][0]};
    endfunction

    // Element k of a row-major triangle sits in the row r with r(r+1)/2 <= k < (r+1)(r+2)/2.
    task automatic model_accept(input int k, input logic [2*DW-1:0] v);
        int r;
        r = 0;
        while ((r + 1) * (r + 2) / 2 <= k) r++;
        model_mem[r][k - r * (r + 1) / 2] = v;
    endtask

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2*DW-1:0] e, input logic ev, input logic [1:0] ra,
                                 input logic rav, input logic cr, input logic cb, input logic fl);
        elem           = e;
        elem_valid     = ev;
        row_addr       = ra;
        row_addr_valid = rav;
        consumer_ready = cr;
        consumer_busy  = cb;
        flush          = fl;
        step_cycle();
    endtask

    task automatic load_stream(input bit gaps);
        int k;
        int guard;
        bit v;
        k = 0;
        guard = 0;
        while (k < NELEM && guard < 200) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            checkOutput("ready_in_load", 512'(elem_ready), 512'(1'b1));
            applyStimulus(stream[k], v, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (v) begin
                model_accept(k, stream[k]);
                k++;
            end
            guard++;
        end
        checkOutput("load_count", 512'(k), 512'(NELEM));
        checkOutput("ready_after_load", 512'(elem_ready), 512'(1'b0));
        checkOutput("loaded_after_load", 512'(loaded), 512'(1'b1));
    endtask

    task automatic arm_and_start(input int delay);
        for (int i = 0; i < delay; i++) begin
            applyStimulus('0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("no_start_while_not_ready", 512'(start), 512'(1'b0));
            checkOutput("no_row_in_arm", 512'(row_valid), 512'(1'b0));
        end
        applyStimulus('0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("start_pulse", 512'(start), 512'(1'b1));
        applyStimulus('0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("start_single", 512'(start), 512'(1'b0));
    endtask

    task automatic read_row(input string name, input logic [1:0] a, input logic [511:0] exp);
        applyStimulus('0, 1'b0, a, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput({name, "_valid"}, 512'(row_valid), 512'(1'b1));
        checkOutput({name, "_addr"}, 512'(row_addr_out), 512'(a));
        checkOutput({name, "_data"}, row_data, exp);
    endtask

    task automatic release_matrix();
        for (int i = 0; i < 20; i++) applyStimulus('0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("ready_while_busy", 512'(elem_ready), 512'(1'b0));
        checkOutput("loaded_while_busy", 512'(loaded), 512'(1'b1));
        applyStimulus('0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ready_after_release", 512'(elem_ready), 512'(1'b1));
        checkOutput("loaded_after_release", 512'(loaded), 512'(1'b0));
    endtask

    initial begin
        tbl[0] = '{2'd2, {128'd0, ek(5), ek(4), ek(3)}};
        tbl[1] = '{2'd0, {128'd0, 128'd0, 128'd0, ek(0)}};
        tbl[2] = '{2'd3, {ek(9), ek(8), ek(7), ek(6)}};
        tbl[3] = '{2'd1, {128'd0, 128'd0, ek(2), ek(1)}};
        tbl[4] = '{2'd3, {ek(9), ek(8), ek(7), ek(6)}};
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) model_mem[r][c] = '0;

        rst_n = 1'b0;
        elem = '0; elem_valid = 1'b0; row_addr = 2'd0; row_addr_valid = 1'b0;
        consumer_ready = 1'b0; consumer_busy = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", 512'(elem_ready), 512'(1'b1));
        checkOutput("reset_loaded", 512'(loaded), 512'(1'b0));
        checkOutput("reset_row_valid", 512'(row_valid), 512'(1'b0));
        checkOutput("reset_start", 512'(start), 512'(1'b0));
        checkOutput("reset_row", row_data, '0);
        checkOutput("reset_row_addr", 512'(row_addr_out), 512'(2'd0));
        checkOutput("reset_diag", 512'(diag_zero), 512'(1'b0));
        rst_n = 1'b1;

        $display("[TB] load e0..e9, start handshake, table reads");
        for (int k = 0; k < NELEM; k++) stream[k] = ek(k);
        load_stream(1'b0);
        arm_and_start(5);
        for (int i = 0; i < 5; i++) begin
            applyStimulus('0, 1'b0, tbl[i].addr, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("tbl_valid", 512'(row_valid), 512'(1'b1));
            checkOutput("tbl_addr", 512'(row_addr_out), 512'(tbl[i].addr));
            checkOutput("tbl_row", row_data, tbl[i].row);
        end
        applyStimulus('0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_no_row", 512'(row_valid), 512'(1'b0));
        release_matrix();

        $display("[TB] second matrix of sevens");
        for (int k = 0; k < NELEM; k++) stream[k] = 128'd7;
        load_stream(1'b0);
        arm_and_start(0);
        read_row("sevens_row1", 2'd1, {128'd0, 128'd0, 128'd7, 128'd7});
        read_row("sevens_row3", 2'd3, {128'd7, 128'd7, 128'd7, 128'd7});
        release_matrix();

        $display("[TB] flush mid-load and during serve");
        for (int k = 0; k < NELEM; k++) stream[k] = ek(k);
        for (int k = 0; k < 4; k++) applyStimulus(stream[k], 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(128'hDEAD, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_load_ready", 512'(elem_ready), 512'(1'b1));
        checkOutput("flush_load_loaded", 512'(loaded), 512'(1'b0));
        load_stream(1'b0);
        arm_and_start(1);
        read_row("reload_row2", 2'd2, {128'd0, ek(5), ek(4), ek(3)});
        read_row("reload_row1", 2'd1, {128'd0, 128'd0, ek(2), ek(1)});
        applyStimulus('0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_serve_valid", 512'(row_valid), 512'(1'b0));
        checkOutput("flush_serve_ready", 512'(elem_ready), 512'(1'b1));
        checkOutput("flush_serve_loaded", 512'(loaded), 512'(1'b0));

        $display("[TB] zero diagonal element");
        stream[2] = '0;
        load_stream(1'b0);
        checkOutput("diag_after_load", 512'(diag_zero), 512'(DIAG_EN));
        arm_and_start(0);
        read_row("diag_row1", 2'd1, {128'd0, 128'd0, 128'd0, ek(1)});
        checkOutput("diag_in_serve", 512'(diag_zero), 512'(DIAG_EN));
        release_matrix();
        checkOutput("diag_after_release", 512'(diag_zero), 512'(1'b0));

        $display("[TB] randomized loads and reads");
        for (int iter = 0; iter < 2; iter++) begin
            for (int k = 0; k < NELEM; k++) stream[k] = {$urandom, $urandom, $urandom, $urandom};
            load_stream(1'b1);
            arm_and_start($urandom_range(0, 4));
            for (int i = 0; i < 40; i++) begin
                logic       v;
                logic [1:0] a;
                v = 1'($urandom_range(0, 1));
                a = 2'($urandom_range(0, 3));
                applyStimulus('0, 1'b0, a, v, 1'b0, 1'b0, 1'b0);
                checkOutput("rand_valid", 512'(row_valid), 512'(v));
                if (v) begin
                    checkOutput("rand_addr", 512'(row_addr_out), 512'(a));
                    checkOutput("rand_row", row_data, model_row(int'(a)));
                end
            end
            release_matrix();
        end

        $display("[TB] asynchronous reset during serve");
        for (int k = 0; k < NELEM; k++) stream[k] = ek(k);
        load_stream(1'b0);
        arm_and_start(0);
        read_row("pre_reset_row3", 2'd3, {ek(9), ek(8), ek(7), ek(6)});
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_loaded", 512'(loaded), 512'(1'b0));
        checkOutput("async_reset_valid", 512'(row_valid), 512'(1'b0));
        checkOutput("async_reset_ready", 512'(elem_ready), 512'(1'b1));
        checkOutput("async_reset_row", row_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus('0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("post_reset_no_row", 512'(row_valid), 512'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
